// File: rtl/bram_arb_pkg.sv
// Shared types and width helpers for the BRAM port arbiter.
// Tag fields are sized from the package defaults below.
package bram_arb_pkg;

    localparam int BRAM_DATA_WIDTH = 32;
    localparam int BRAM_RAM_DEPTH  = 256;
    localparam int BRAM_NUM_REQ    = 4;

    // $clog2 that never yields a zero-width vector.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    localparam int BRAM_AW = clog2_min1(BRAM_RAM_DEPTH);
    localparam int BRAM_IW = clog2_min1(BRAM_NUM_REQ);

    typedef struct packed {
        logic                       valid;
        logic [BRAM_IW-1:0]         id;
        logic                       fwd_valid;
        logic [BRAM_DATA_WIDTH-1:0] fwd_data;
    } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer and wraps; after a grant
// to k the pointer moves to k+1, with no request it holds.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = clog2_min1(N)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);

    logic [IW-1:0] ptr;

    always_comb begin
        int   idx;
        logic found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IW'(idx);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one simple-dual-port read-first BRAM between NUM_REQ requesters with
// independent write/read round-robin arbiters. Optional macro: BRAM_ARB_WR_FORWARD_EN.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = BRAM_DATA_WIDTH,
    parameter  int RAM_DEPTH  = BRAM_RAM_DEPTH,
    parameter  int NUM_REQ    = BRAM_NUM_REQ,
    parameter  int RD_LATENCY = 1,
    localparam int AW         = clog2_min1(RAM_DEPTH),
    localparam int IW         = clog2_min1(NUM_REQ)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_we,
    input  logic [NUM_REQ*AW-1:0]         i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_ram_we,
    output logic [AW-1:0]                 o_ram_w_addr,
    output logic [DATA_WIDTH-1:0]         o_ram_w_data,
    output logic                          o_ram_re,
    output logic [AW-1:0]                 o_ram_r_addr,
    input  logic [DATA_WIDTH-1:0]         i_ram_r_data,
    output logic                          o_rsp_valid,
    output logic [IW-1:0]                 o_rsp_id,
    output logic [DATA_WIDTH-1:0]         o_rsp_data
);

    logic [NUM_REQ-1:0] wr_cand, rd_cand, wr_gnt, rd_gnt;
    logic [IW-1:0]      wr_id, rd_id;
    logic               wr_hs, rd_hs, fwd_hit;
    rd_tag_t            tag_q [RD_LATENCY+1];

    // Handshake: a request transfers in the cycle where valid & ready are both
    // high; ready is combinational, so a granted candidate always transfers.
    assign wr_cand = i_req_valid & i_req_we;
    assign rd_cand = i_req_valid & ~i_req_we;
    assign wr_hs   = |wr_cand;
    assign rd_hs   = |rd_cand;

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .CLK    (CLK),
        .RST    (RST),
        .req    (wr_cand),
        .advance(wr_hs),
        .gnt    (wr_gnt),
        .gnt_id (wr_id)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .CLK    (CLK),
        .RST    (RST),
        .req    (rd_cand),
        .advance(rd_hs),
        .gnt    (rd_gnt),
        .gnt_id (rd_id)
    );

    assign o_req_ready = RST ? '0 : (wr_gnt | rd_gnt);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_ram_we     <= 1'b0;
            o_ram_w_addr <= '0;
            o_ram_w_data <= '0;
            o_ram_re     <= 1'b0;
            o_ram_r_addr <= '0;
        end else begin
            o_ram_we <= wr_hs;
            o_ram_re <= rd_hs;
            if (wr_hs) begin
                o_ram_w_addr <= i_req_addr[int'(wr_id)*AW +: AW];
                o_ram_w_data <= i_req_wdata[int'(wr_id)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_hs) begin
                o_ram_r_addr <= i_req_addr[int'(rd_id)*AW +: AW];
            end
        end
    end

`ifdef BRAM_ARB_WR_FORWARD_EN
    assign fwd_hit = o_ram_re & o_ram_we & (o_ram_r_addr == o_ram_w_addr);
`else
    assign fwd_hit = 1'b0;
`endif

    // Stage 0 lines up with the issued read; the last stage with returned data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: rd_hs, id: rd_id, fwd_valid: 1'b0, fwd_data: '0};
            for (int i = 1; i <= RD_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (fwd_hit) begin
                tag_q[1].fwd_valid <= 1'b1;
                tag_q[1].fwd_data  <= o_ram_w_data;
            end
        end
    end

    assign o_rsp_valid = tag_q[RD_LATENCY].valid;
    assign o_rsp_id    = tag_q[RD_LATENCY].id;
    assign o_rsp_data  = !tag_q[RD_LATENCY].valid   ? '0 :
                         tag_q[RD_LATENCY].fwd_valid ? tag_q[RD_LATENCY].fwd_data :
                                                       i_ram_r_data;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: table vectors, hand sequences and random traffic
// checked against a read-first memory model and round-robin grant rules.
module tb_bram_port_arbiter;

  localparam int DW     = 32;
  localparam int DEPTH  = 256;
  localparam int NR     = 4;
  localparam int RD_LAT = 2;
  localparam int AW     = 8;
  localparam int IW     = 2;
`ifdef BRAM_ARB_WR_FORWARD_EN
  localparam logic [DW-1:0] COL_EXP = 32'hAAAA;
`else
  localparam logic [DW-1:0] COL_EXP = 32'h5555;
`endif

  // clock / reset
  logic CLK = 1'b0;
  logic RST;
  int   cyc = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [NR-1:0]    req_valid, req_we, o_req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic             o_ram_we, o_ram_re, o_rsp_valid;
  logic [AW-1:0]    o_ram_w_addr, o_ram_r_addr;
  logic [DW-1:0]    o_ram_w_data, i_ram_r_data, o_rsp_data;
  logic [IW-1:0]    o_rsp_id;

  bram_port_arbiter #(
    .DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .NUM_REQ(NR), .RD_LATENCY(RD_LAT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_req_ready(o_req_ready),
    .o_ram_we(o_ram_we), .o_ram_w_addr(o_ram_w_addr), .o_ram_w_data(o_ram_w_data),
    .o_ram_re(o_ram_re), .o_ram_r_addr(o_ram_r_addr), .i_ram_r_data(i_ram_r_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data)
  );

  // read-first BRAM environment with RD_LAT cycles of read latency
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rpipe [RD_LAT];
  always @(posedge CLK) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (o_ram_we) mem[o_ram_w_addr] <= o_ram_w_data;
    if (o_ram_re) rpipe[0] <= mem[o_ram_r_addr];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign i_ram_r_data = rpipe[RD_LAT-1];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: expected responses, shadow memory, model pointers
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t          exp_q[$];
  rsp_t          r;
  logic [DW-1:0] shadow [DEPTH];
  int            wptr_m = 0, rptr_m = 0, wk, rk;
  logic          exp_we = 1'b0, exp_re = 1'b0;
  logic [AW-1:0] exp_waddr, exp_raddr;
  logic [DW-1:0] exp_wdata, rd;
  logic [NR-1:0] wc, rc, exp_rdy;

  function automatic int rr_pick(input int ptr, input logic [NR-1:0] cand);
    for (int i = 0; i < NR; i++) begin
      if (cand[(ptr + i) % NR]) return (ptr + i) % NR;
    end
    return -1;
  endfunction

  always @(negedge CLK) begin
    if (pl_en) shadow[pl_addr] = pl_data;
    if (RST) begin
      check("rst_ctrl", {o_req_ready, o_ram_we, o_ram_re, o_rsp_valid, o_rsp_id,
                         o_ram_w_addr, o_ram_r_addr}, '0);
      check("rst_data", {o_ram_w_data, o_rsp_data}, '0);
      wptr_m = 0; rptr_m = 0; exp_we = 1'b0; exp_re = 1'b0;
      exp_q.delete();
    end else begin
      check("ram_we", o_ram_we, exp_we);
      if (exp_we) begin
        check("ram_w_addr", o_ram_w_addr, exp_waddr);
        check("ram_w_data", o_ram_w_data, exp_wdata);
      end
      check("ram_re", o_ram_re, exp_re);
      if (exp_re) check("ram_r_addr", o_ram_r_addr, exp_raddr);
      if (o_rsp_valid) begin
        if (exp_q.size() == 0) check("rsp_unexpected", o_rsp_valid, 1'b0);
        else begin
          r = exp_q.pop_front();
          check("rsp_cycle", cyc, r.due);
          check("rsp_id", o_rsp_id, r.id);
          check("rsp_data", o_rsp_data, r.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("rsp_missing", o_rsp_valid, 1'b1);
        void'(exp_q.pop_front());
      end
      wc = req_valid & req_we;
      rc = req_valid & ~req_we;
      wk = rr_pick(wptr_m, wc);
      rk = rr_pick(rptr_m, rc);
      exp_rdy = '0;
      if (wk >= 0) exp_rdy[wk] = 1'b1;
      if (rk >= 0) exp_rdy[rk] = 1'b1;
      check("req_ready", o_req_ready, exp_rdy);
      exp_we = (wk >= 0);
      exp_re = (rk >= 0);
      if (wk >= 0) begin
        exp_waddr = req_addr[wk*AW +: AW];
        exp_wdata = req_wdata[wk*DW +: DW];
      end
      if (rk >= 0) begin
        exp_raddr = req_addr[rk*AW +: AW];
        rd = shadow[exp_raddr];
`ifdef BRAM_ARB_WR_FORWARD_EN
        if (wk >= 0 && exp_waddr == exp_raddr) rd = exp_wdata;
`endif
        exp_q.push_back('{due: cyc + 1 + RD_LAT, id: rk, data: rd});
        rptr_m = (rk + 1) % NR;
      end
      if (wk >= 0) begin
        shadow[exp_waddr] = exp_wdata;
        wptr_m = (wk + 1) % NR;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k] = v;
    req_we[k]    = we;
    req_addr[k*AW +: AW]  = a;
    req_wdata[k*DW +: DW] = d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tick();
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] we;
    logic [NR-1:0] ready;
  } vec_t;
  vec_t          tbl [14];
  logic [NR-1:0] hs;

  initial begin
    tbl[0]  = '{4'b1111, 4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b1111, 4'b0001};
    tbl[5]  = '{4'b0011, 4'b0001, 4'b0011};
    tbl[6]  = '{4'b1000, 4'b0000, 4'b1000};
    tbl[7]  = '{4'b1000, 4'b0000, 4'b1000};
    tbl[8]  = '{4'b1000, 4'b0000, 4'b1000};
    tbl[9]  = '{4'b1001, 4'b0000, 4'b0001};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000};
    tbl[11] = '{4'b0101, 4'b0101, 4'b0100};
    tbl[12] = '{4'b1111, 4'b1010, 4'b1100};
    tbl[13] = '{4'b1111, 4'b0000, 4'b1000};

    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    RST = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      tick();
      pl_en = 1'b1; pl_addr = AW'(a); pl_data = $urandom;
    end
    tick();
    pl_en = 1'b0;
    RST = 1'b0;

    // table: grants from reset pointers
    for (int i = 0; i < 14; i++) begin
      tick();
      req_valid = tbl[i].valid;
      req_we    = tbl[i].we;
      for (int k = 0; k < NR; k++) begin
        req_addr[k*AW +: AW]  = AW'($urandom_range(0, 255));
        req_wdata[k*DW +: DW] = $urandom;
      end
      @(negedge CLK);
      check($sformatf("tbl_ready[%0d]", i), o_req_ready, tbl[i].ready);
    end
    tick();
    req_valid = '0;
    repeat (6) tick();

    // single read from requester 2
    preload(8'h10, 32'hDEAD);
    drive(2, 1'b1, 1'b0, 8'h10, '0);
    @(negedge CLK);
    check("sr_ready", o_req_ready, 4'b0100);
    tick();
    req_valid = '0;
    @(negedge CLK);
    check("sr_ram_re", o_ram_re, 1'b1);
    check("sr_r_addr", o_ram_r_addr, 8'h10);
    repeat (RD_LAT) @(negedge CLK);
    check("sr_rsp_valid", o_rsp_valid, 1'b1);
    check("sr_rsp_id", o_rsp_id, 2'd2);
    check("sr_rsp_data", o_rsp_data, 32'hDEAD);

    // concurrent write and read from different requesters
    tick();
    drive(0, 1'b1, 1'b1, 8'd5, 32'h1234);
    drive(1, 1'b1, 1'b0, 8'd7, '0);
    @(negedge CLK);
    check("cc_ready", o_req_ready, 4'b0011);
    tick();
    req_valid = '0;
    @(negedge CLK);
    check("cc_ram_ops", {o_ram_we, o_ram_re}, 2'b11);
    check("cc_w", {o_ram_w_addr, o_ram_w_data}, {8'd5, 32'h1234});
    check("cc_r_addr", o_ram_r_addr, 8'd7);
    repeat (4) tick();

    // same-address collision
    preload(8'd3, 32'h5555);
    drive(0, 1'b1, 1'b1, 8'd3, 32'hAAAA);
    drive(1, 1'b1, 1'b0, 8'd3, '0);
    @(negedge CLK);
    check("col_ready", o_req_ready, 4'b0011);
    tick();
    req_valid = '0;
    repeat (1 + RD_LAT) @(negedge CLK);
    check("col_rsp_valid", o_rsp_valid, 1'b1);
    check("col_rsp_data", o_rsp_data, COL_EXP);

    // pointer wrap: requester 3 alone, then 0 and 3
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(3, 1'b1, 1'b0, AW'($urandom_range(0, 255)), '0);
      @(negedge CLK);
      check("ph_only3", o_req_ready, 4'b1000);
    end
    tick();
    drive(0, 1'b1, 1'b0, AW'($urandom_range(0, 255)), '0);
    @(negedge CLK);
    check("ph_wrap", o_req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (6) tick();

    // reset one cycle after a read grant
    drive(2, 1'b1, 1'b0, 8'h20, '0);
    @(negedge CLK);
    check("rm_ready", o_req_ready, 4'b0100);
    tick();
    req_valid = '0;
    drive(1, 1'b1, 1'b0, 8'h21, '0);
    RST = 1'b1;
    @(negedge CLK);
    check("rm_outputs", {o_req_ready, o_ram_re, o_rsp_valid}, '0);
    tick();
    req_valid = '0;
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("rm_no_rsp", o_rsp_valid, 1'b0);
    end

    // random traffic; requests hold their fields until granted
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      hs = req_valid & o_req_ready;
      tick();
      for (int k = 0; k < NR; k++) begin
        if (!req_valid[k] || hs[k]) begin
          if ($urandom_range(0, 2) != 0)
            drive(k, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
          else
            req_valid[k] = 1'b0;
        end
      end
    end
    @(negedge CLK);
    tick();
    req_valid = '0;
    repeat (8) tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
